// File: rtl/bin16_to_bcd.sv
// ---------------------------------------------------------------------------
// bin16_to_bcd
//
// Converts a 16-bit unsigned sum into five packed BCD digits using the
// shift-and-add-3 (double dabble) method, one bit per clock. The overflow
// flag from the upstream sum-of-products stage travels with the operand.
// A leading-zero blank mask is produced alongside the digits for a
// seven-segment display.
//
// Parameters
//   LZB      1 = leading-zero blank mask active, 0 = blank forced to zero
//
// Ports
//   clk      single clock, all state changes on its rising edge
//   reset    synchronous, active-high reset
//   start    conversion request, only looked at while idle
//   bin      16-bit unsigned operand
//   ovf_in   overflow flag captured together with bin
//   bcd      five packed BCD digits, [19:16] ten-thousands .. [3:0] units
//   blank    per-digit leading-zero flag, bit i covers bcd[4i+3:4i]
//   ovf_out  overflow flag belonging to the last completed conversion
//   busy     high while a conversion is running (SHIFT or DONE)
//   done     one-cycle pulse, bcd/blank/ovf_out just became valid
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bin16_to_bcd #(
    parameter bit LZB = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] bin,
    input  logic        ovf_in,
    output logic [19:0] bcd,
    output logic [4:0]  blank,
    output logic        ovf_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A zero result still shows a single "0", so the units digit is never dark.
    localparam logic [4:0] BLANK_RST = LZB ? 5'b11110 : 5'b00000;

    state_t      state_q, state_d;
    logic [35:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_cap_q, ovf_cap_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  blank_q, blank_d;
    logic        ovf_out_q, ovf_out_d;
    logic [35:0] adj;
    logic [35:0] shifted;

    // Blank flags ripple down from the most significant digit: a digit is dark
    // only if it and every digit above it are zero.
    function automatic logic [4:0] calc_blank(input logic [19:0] d);
        logic [4:0] b;
        b = 5'b00000;
        if (LZB) begin
            b[4] = (d[19:16] == 4'd0);
            b[3] = b[4] && (d[15:12] == 4'd0);
            b[2] = b[3] && (d[11:8]  == 4'd0);
            b[1] = b[2] && (d[7:4]   == 4'd0);
        end
        return b;
    endfunction

    // One double-dabble step: correct every BCD nibble that would overflow
    // past 9 when doubled, then shift the whole register left by one.
    always_comb begin
        adj = sr_q;
        for (int i = 0; i < 5; i++) begin
            if (adj[16 + 4*i +: 4] >= 4'd5) begin
                adj[16 + 4*i +: 4] = adj[16 + 4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[34:0], 1'b0};
    end

    // Next-state and datapath control. Result registers are only loaded on
    // the edge that completes the last shift, so they hold steady otherwise.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovf_cap_d = ovf_cap_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        ovf_out_d = ovf_out_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = {20'd0, bin};
                    ovf_cap_d = ovf_in;
                    cnt_d     = 5'd16;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy  = 1'b1;
                sr_d  = shifted;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    bcd_d     = shifted[35:16];
                    blank_d   = calc_blank(shifted[35:16]);
                    ovf_out_d = ovf_cap_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset wins over any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= 36'd0;
            cnt_q     <= 5'd0;
            ovf_cap_q <= 1'b0;
            bcd_q     <= 20'd0;
            blank_q   <= BLANK_RST;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_cap_q <= ovf_cap_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign bcd     = bcd_q;
    assign blank   = blank_q;
    assign ovf_out = ovf_out_q;

endmodule

// File: doc/bin16_to_bcd.md
BIN16_TO_BCD -- requirements
Module: bin16_to_bcd

Interface
REQ-001 Parameter: LZB, default 1, meaning 1 = leading-zero blank mask active, 0 = blank output forced to 0.
REQ-002 Clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request to convert; sampled only in IDLE.
REQ-005 bin  in  16  unsigned binary sum from the sum-of-products stage.
REQ-006 ovf_in  in  1  carry/overflow flag from the sum-of-products stage.
REQ-007 bcd  out  20  five packed BCD digits; [19:16] = ten-thousands, [3:0] = units.
REQ-008 blank  out  5  per-digit leading-zero flag; bit i covers bcd[4i+3:4i]; 1 = display dark.
REQ-009 ovf_out  out  1  ovf_in captured with the operand of the last completed conversion.
REQ-010 busy  out  1  high while a conversion is in progress (SHIFT or DONE state).
REQ-011 done  out  1  one-cycle pulse; bcd, blank and ovf_out are updated and valid.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at an edge SHALL capture bin into a 36-bit shift register (upper 20 bits zero) and capture ovf_in; load a bit counter with 16; go to SHIFT.
REQ-014 IDLE with start=0 SHALL hold all outputs.
REQ-015 Each SHIFT edge SHALL (a) add 3 to every BCD nibble >= 5, then (b) shift the whole 36-bit register left by 1 and decrement the counter.
REQ-016 On the edge that performs the 16th shift, the block SHALL load bcd from the post-shift upper 20 bits, load blank and ovf_out, and enter DONE.
REQ-017 done SHALL be 1 only while in DONE, and DONE SHALL go to IDLE on the next edge unconditionally.
REQ-018 Latency: done SHALL rise on the 16th edge after the capture edge; a continuously high start SHALL yield one conversion per 18 edges.
REQ-019 start in SHIFT or DONE SHALL be ignored and SHALL NOT be queued; bin/ovf_in changes after capture SHALL NOT affect the result.
REQ-020 bcd, blank and ovf_out SHALL change only on the DONE-entry edge or on reset, and hold otherwise.
REQ-021 With LZB=1, blank[i] SHALL be 1 iff digit i and all higher digits are zero, for i = 4..1; blank[0] SHALL always be 0 (value 0 shows "0").
REQ-022 With LZB=0, blank SHALL be 5'b00000.
REQ-023 Range: bin = 0..65535 SHALL convert exactly; no nibble of bcd SHALL exceed 9; bcd[19:16] SHALL never exceed 6.

Reset
REQ-024 Reset=1 at an edge SHALL force IDLE, counter=0, shift register=0, bcd=0, blank=5'b11110 (LZB=1) or 0 (LZB=0), ovf_out=0, busy=0, done=0.
REQ-025 Reset SHALL take priority over start and over any in-progress conversion; an aborted conversion SHALL NOT produce done or update outputs.
REQ-026 The first start sampled after Reset returns to 0 SHALL be accepted normally.

Verification
REQ-027 bin=0, start pulse -> 16 edges later done=1 for one cycle, bcd=20'h00000, blank=5'b11110, busy high for exactly 17 cycles.
REQ-028 bin=16'hFFFF, ovf_in=1 -> bcd=20'h65535, blank=5'b00000, ovf_out=1.
REQ-029 bin=1234 then bin=9 (separate starts) -> bcd=20'h01234, blank=5'b10000; then bcd=20'h00009, blank=5'b11110.
REQ-030 start re-pulsed at edges 3 and 16 after capture with different bin -> single done, result matches the first captured value.
REQ-031 Reset asserted 8 edges after capture -> no done, bcd=0, busy=0; next start with bin=500 -> bcd=20'h00500 after 16 edges.
REQ-032 start held high, bin stepped 0..1000 -> done every 18 edges, every bcd matches the reference decimal value, and no nibble exceeds 9.
